// File: rtl/issue_ctrl_pkg.sv
// rtl/issue_ctrl_pkg.sv - shared widths, issue FSM states and issue payload type
package issue_ctrl_pkg;

    localparam int XLEN         = 32;
    localparam int NB_UNIT      = 6;
    localparam int NB_OPERATION = 6;
    localparam int NB_REG       = 32;

    typedef enum logic [1:0] {
        ISS_RUN,
        ISS_DRAIN,
        ISS_SERIAL
    } issue_state_t;

    typedef struct packed {
        logic                    rd_v;
        logic [4:0]              rd_adr;
        logic [NB_UNIT-1:0]      unit;
        logic [NB_OPERATION-1:0] operation;
    } issue_payload_t;

endpackage

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - per-register pending-write counters and RAW/WAW hazard detection
module issue_scoreboard
    import issue_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush_i,
    input  logic       acc_i,
    input  logic       rd_v_i,
    input  logic [4:0] rd_adr_i,
    input  logic       rs1_v_i,
    input  logic [4:0] rs1_adr_i,
    input  logic       rs2_v_i,
    input  logic [4:0] rs2_adr_i,
    input  logic       wbk_v_i,
    input  logic [4:0] wbk_adr_i,
    output logic       hazard_o
);

    // Entry 0 is never written, so x0 always reads as "nothing pending".
    logic [1:0]        r_pend [NB_REG];
    logic [NB_REG-1:0] w_inc;
    logic [NB_REG-1:0] w_dec;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 1; i < NB_REG; i++) begin
            w_inc[i] = acc_i & rd_v_i & (rd_adr_i == 5'(i));
            w_dec[i] = wbk_v_i & (wbk_adr_i == 5'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            for (int i = 0; i < NB_REG; i++) r_pend[i] <= 2'd0;
        end else begin
            for (int i = 1; i < NB_REG; i++) begin
                if (w_inc[i] && !w_dec[i])
                    r_pend[i] <= r_pend[i] + 2'd1;
                else if (w_dec[i] && !w_inc[i] && r_pend[i] != 2'd0)
                    r_pend[i] <= r_pend[i] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush_i) begin
            for (int i = 1; i < NB_REG; i++)
                assert (!(w_dec[i] && !w_inc[i] && r_pend[i] == 2'd0));
        end
    end

    // Registered counts only: a writeback does not unblock its reader until the next cycle.
    assign hazard_o = (rs1_v_i && r_pend[rs1_adr_i] != 2'd0)
                    | (rs2_v_i && r_pend[rs2_adr_i] != 2'd0)
                    | (rd_v_i  && r_pend[rd_adr_i]  == 2'd3);

endmodule

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - issue controller: hazard/inflight stalls, CSR serialisation, one-entry issue slot
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int NB_INFLIGHT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dec_valid_i,
    output logic                    dec_ready_o,
    input  logic                    dec_rd_v_i,
    input  logic [4:0]              dec_rd_adr_i,
    input  logic                    dec_rs1_v_i,
    input  logic [4:0]              dec_rs1_adr_i,
    input  logic                    dec_rs2_v_i,
    input  logic [4:0]              dec_rs2_adr_i,
    input  logic [NB_UNIT-1:0]      dec_unit_i,
    input  logic [NB_OPERATION-1:0] dec_operation_i,
    input  logic                    dec_serial_i,
    output logic                    exe_valid_o,
    input  logic                    exe_ready_i,
    output logic                    exe_rd_v_o,
    output logic [4:0]              exe_rd_adr_o,
    output logic [NB_UNIT-1:0]      exe_unit_o,
    output logic [NB_OPERATION-1:0] exe_operation_o,
    input  logic                    wbk_v_i,
    input  logic [4:0]              wbk_adr_i,
    input  logic                    commit_i,
    input  logic                    flush_i,
    output logic                    busy_o
);

    localparam int CW = $clog2(NB_INFLIGHT + 1);

    issue_state_t   r_state;
    logic [CW-1:0]  r_inflight;
    logic           r_exe_valid;
    issue_payload_t r_payload;

    logic w_hazard;
    logic w_busy;
    logic w_full;
    logic w_slot_free;
    logic w_permit;
    logic w_accept;

    issue_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush_i),
        .acc_i     (w_accept),
        .rd_v_i    (dec_rd_v_i),
        .rd_adr_i  (dec_rd_adr_i),
        .rs1_v_i   (dec_rs1_v_i),
        .rs1_adr_i (dec_rs1_adr_i),
        .rs2_v_i   (dec_rs2_v_i),
        .rs2_adr_i (dec_rs2_adr_i),
        .wbk_v_i   (wbk_v_i),
        .wbk_adr_i (wbk_adr_i),
        .hazard_o  (w_hazard)
    );

    assign w_busy      = (r_inflight != '0) | r_exe_valid;
    assign w_full      = (r_inflight == CW'(NB_INFLIGHT));
    assign w_slot_free = ~r_exe_valid | exe_ready_i;

    // A serialising instruction only issues into a completely idle pipeline.
    always_comb begin
        w_permit = 1'b0;
        if (r_state == ISS_RUN)
            w_permit = ~dec_serial_i | ~w_busy;
    end

    assign w_accept = ~rst & dec_valid_i & w_slot_free & ~w_hazard & ~w_full & w_permit & ~flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ISS_RUN;
            r_inflight  <= '0;
            r_exe_valid <= 1'b0;
            r_payload   <= '0;
        end else if (flush_i) begin
            r_state     <= ISS_RUN;
            r_inflight  <= '0;
            r_exe_valid <= 1'b0;
        end else begin
            assert (!(commit_i && !w_accept && r_inflight == '0));

            if (w_accept && !commit_i)
                r_inflight <= r_inflight + CW'(1);
            else if (!w_accept && commit_i && r_inflight != '0)
                r_inflight <= r_inflight - CW'(1);

            if (w_accept) begin
                r_exe_valid <= 1'b1;
                r_payload   <= '{rd_v:      dec_rd_v_i,
                                 rd_adr:    dec_rd_adr_i,
                                 unit:      dec_unit_i,
                                 operation: dec_operation_i};
            end else if (exe_ready_i) begin
                r_exe_valid <= 1'b0;
            end

            case (r_state)
                ISS_RUN: begin
                    if (dec_valid_i && dec_serial_i) begin
                        if (w_busy)
                            r_state <= ISS_DRAIN;
                        else if (w_accept)
                            r_state <= ISS_SERIAL;
                    end
                end
                ISS_DRAIN: begin
                    if (!w_busy)
                        r_state <= ISS_RUN;
                end
                ISS_SERIAL: begin
                    if (commit_i && r_inflight == CW'(1))
                        r_state <= ISS_RUN;
                end
                default: r_state <= ISS_RUN;
            endcase
        end
    end

    assign dec_ready_o     = w_accept;
    assign exe_valid_o     = r_exe_valid;
    assign exe_rd_v_o      = r_payload.rd_v;
    assign exe_rd_adr_o    = r_payload.rd_adr;
    assign exe_unit_o      = r_payload.unit;
    assign exe_operation_o = r_payload.operation;
    assign busy_o          = w_busy;

endmodule
